lut_fabric: RTL and testbench
=============================

# lut_fabric

Parametrised successor to the current 5-in/5-out tinyFPGA core. It provides a configurable array of K-input LUT cells, each with its own flip-flop, loaded through a serial configuration shift chain. A daisy-chain tap (`prog_out`) allows readback or cascading of devices. New relative to the current core: generic width, depth and LUT size; loop-free registered feedback routing; a bit-count check that drives a `cfg_valid` flag gating the fabric outputs.

## Interface
Parameters:
- `N_IN`, 5: number of fabric input pins.
- `N_OUT`, 5: number of fabric output pins.
- `N_LUT`, 8: number of LUT cells.
- `K`, 3: inputs per LUT; truth table is 2^K bits.

Derived (not overridable):
- `SEL_W` = clog2(N_IN+N_LUT).
- `OSEL_W` = clog2(N_LUT).
- `CW` = 2^K + K*SEL_W + 1.
- `CFG_W` = N_LUT*CW + N_OUT*OSEL_W. Defaults give SEL_W=4, CW=21, OSEL_W=3, CFG_W=183.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prog_en`  in  1  1 = shift configuration, fabric halted.
- `prog_data`  in  1  serial configuration bit.
- `prog_out`  out  1  tail of config chain (cfg[0]), registered.
- `fabric_in`  in  N_IN  user inputs.
- `fabric_out`  out  N_OUT  user outputs.
- `cfg_valid`  out  1  1 = last session shifted exactly CFG_W bits.

## Operation
- Config register `cfg[CFG_W-1:0]`:
  - LUT j occupies `cfg[j*CW +: CW]`.
  - Within a LUT field:
    - bits [2^K-1:0] hold the truth table.
    - select for LUT input i sits at `2^K + i*SEL_W`.
    - the top bit is `mode` (0 = combinational output, 1 = registered output).
  - Output o select sits at `cfg[N_LUT*CW + o*OSEL_W +: OSEL_W]`.
- Shift: while `prog_en`=1, each clk performs `cfg <= {prog_data, cfg[CFG_W-1:1]}`. The first bit shifted lands in cfg[0] after CFG_W shifts.
- Routing sources for LUT inputs:
  - index < N_IN: `fabric_in[index]`.
  - N_IN ≤ index < N_IN+N_LUT: register `q[index-N_IN]`.
  - larger index: reads 0.
  - LUT inputs never see comb LUT values, so no combinational loops are possible.
- LUT j computes `c_j = truth[{x_{K-1},…,x_0}]`. Its register updates `q_j <= c_j` every clk while `prog_en`=0 and `cfg_valid`=1; otherwise `q_j <= 0`.
- Output o takes LUT s = its select value:
  - `fabric_out[o] = mode_s ? q_s : c_s`.
  - A select value ≥ N_LUT gives 0.
  - Whole bus forced to 0 when `cfg_valid`=0 or `prog_en`=1.
- Bit counter `cnt`, width clog2(CFG_W+2):
  - cleared on the first `prog_en` cycle of a session (prog_en rising).
  - +1 per shift, saturating at CFG_W+1.
- `cfg_valid`:
  - clears on the clk where `prog_en` is first seen high.
  - on the clk where `prog_en` is first seen low after a session, set to (cnt == CFG_W).
- Reset: cfg=0, q=0, cnt=0, cfg_valid=0, prog_out=0, fabric_out=0. Reset wins over `prog_en` in the same cycle.
- Reset mid-session discards the session. `cfg_valid` stays 0 until a complete session finishes.

## Timing
- Comb-mode path `fabric_in` → `fabric_out`: 0 cycles.
- Registered-mode path: 1 cycle.
- Feedback through q: 1 cycle per hop.
- `prog_out` is cfg[0]. A bit presented on `prog_data` appears on `prog_out` CFG_W clocks later, so devices daisy-chain directly.
- Session of exactly CFG_W cycles with prog_en=1:
  - the clk with prog_en=0 registers cfg_valid=1.
  - fabric_out becomes live in that same cycle (comb mode).
  - q starts updating from the following clk.
- Wrong session length (CFG_W−1, or CFG_W+1 or more): cfg_valid=0 and fabric_out=0 until a correct session completes.
- Single-cycle prog_en glitch: counts as a session of length 1, so cfg_valid drops to 0.

## Structure
- Package `lut_fabric_pkg`:
  - clog2 helper.
  - functions computing SEL_W, OSEL_W, CW, CFG_W from parameters.
  - field-offset functions for truth, select and mode, shared with the bench bitstream builder.
- Sub-module `lut_cell` (params K, N_SRC, SEL_W):
  - takes source vector and CW-bit config slice.
  - contains K select muxes, truth-table mux and q register with sync clear/enable.
  - outputs c, q, mode.
- Top instantiates N_LUT `lut_cell` and contains the shift register, counter, cfg_valid logic and output muxes.

## Test plan
- AND gate, defaults:
  - program LUT0 with truth 8'h08, sel0=0, sel1=1, sel2=15, mode 0; out0 sel=0; other LUTs all-zero.
  - fabric_in=5'b00011 → fabric_out[0]=1 same cycle.
  - 5'b00001 → 0.
- Toggle:
  - LUT1 truth 8'h55, sel0=6 (its own q), mode 1; out1 sel=1.
  - after valid load, fabric_out[1] alternates 0,1,0,1… from the second post-load clk.
- Length check:
  - shift 182 bits, drop prog_en → cfg_valid=0, fabric_out=0.
  - repeat with 184 bits → same.
  - with 183 bits → cfg_valid=1.
- Readback: shift pattern P (183 bits) then 183 zeros → prog_out reproduces P bit-for-bit during the second 183 cycles.
- Reset mid-session: assert rst at shift 100 → next cycle cfg=0, cfg_valid=0, prog_out=0; a fresh full load then yields cfg_valid=1.
- Re-program while running: prog_en high one cycle during toggle test → next clk cfg_valid=0 and fabric_out=0, q cleared.

Source files
------------

// File: rtl/lut_fabric_pkg.sv
// Shared sizing and bitstream field-offset helpers for lut_fabric.
// Used by the RTL and by anything that builds configuration bitstreams.
package lut_fabric_pkg;

    // Ceiling log2, never below 1 so derived vector widths stay legal.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r++;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    function automatic int unsigned calc_sel_w(input int unsigned n_in, input int unsigned n_lut);
        return clog2(n_in + n_lut);
    endfunction

    function automatic int unsigned calc_osel_w(input int unsigned n_lut);
        return clog2(n_lut);
    endfunction

    function automatic int unsigned calc_cw(input int unsigned k, input int unsigned sel_w);
        return (32'd1 << k) + k * sel_w + 1;
    endfunction

    function automatic int unsigned calc_cfg_w(input int unsigned n_lut, input int unsigned n_out,
                                               input int unsigned cw, input int unsigned osel_w);
        return n_lut * cw + n_out * osel_w;
    endfunction

    function automatic int unsigned truth_off(input int unsigned j, input int unsigned cw);
        return j * cw;
    endfunction

    function automatic int unsigned sel_off(input int unsigned j, input int unsigned i,
                                            input int unsigned k, input int unsigned cw,
                                            input int unsigned sel_w);
        return j * cw + (32'd1 << k) + i * sel_w;
    endfunction

    function automatic int unsigned mode_off(input int unsigned j, input int unsigned cw);
        return j * cw + cw - 1;
    endfunction

    function automatic int unsigned osel_off(input int unsigned o, input int unsigned n_lut,
                                             input int unsigned cw, input int unsigned osel_w);
        return n_lut * cw + o * osel_w;
    endfunction

endpackage

// File: rtl/lut_cell.sv
// One K-input LUT with routed input selects and an output flip-flop.
// Select values beyond the source vector read as 0.
module lut_cell
    import lut_fabric_pkg::*;
#(
    parameter int unsigned K     = 3,
    parameter int unsigned N_SRC = 13,
    parameter int unsigned SEL_W = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_SRC-1:0]               i_src,
    input  logic [calc_cw(K, SEL_W)-1:0]   i_cfg,
    input  logic                           i_en,
    output logic                           o_c,
    output logic                           o_q,
    output logic                           o_mode
);

    localparam int unsigned CW   = calc_cw(K, SEL_W);
    localparam int unsigned TT_W = 32'd1 << K;

    logic [K-1:0]      w_x;
    logic [SEL_W-1:0]  w_sel;
    logic [TT_W-1:0]   w_tt;
    logic              r_q;

    always_comb begin
        w_x   = '0;
        w_sel = '0;
        for (int i = 0; i < int'(K); i++) begin
            w_sel = i_cfg[TT_W + i * SEL_W +: SEL_W];
            if (32'(w_sel) < N_SRC) begin
                w_x[i] = i_src[w_sel];
            end
        end
    end

    assign w_tt   = i_cfg[TT_W-1:0];
    assign o_c    = w_tt[w_x];
    assign o_mode = i_cfg[CW-1];
    assign o_q    = r_q;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_q <= 1'b0;
        end else begin
            r_q <= o_c;
        end
    end

endmodule

// File: rtl/lut_fabric.sv
// Configurable LUT fabric: serial config chain, registered-feedback routing,
// and a session bit-count check gating the outputs through cfg_valid.
module lut_fabric
    import lut_fabric_pkg::*;
#(
    parameter int unsigned N_IN  = 5,
    parameter int unsigned N_OUT = 5,
    parameter int unsigned N_LUT = 8,
    parameter int unsigned K     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_en,
    input  logic             prog_data,
    output logic             prog_out,
    input  logic [N_IN-1:0]  fabric_in,
    output logic [N_OUT-1:0] fabric_out,
    output logic             cfg_valid
);

    localparam int unsigned SEL_W  = calc_sel_w(N_IN, N_LUT);
    localparam int unsigned OSEL_W = calc_osel_w(N_LUT);
    localparam int unsigned CW     = calc_cw(K, SEL_W);
    localparam int unsigned CFG_W  = calc_cfg_w(N_LUT, N_OUT, CW, OSEL_W);
    localparam int unsigned CNT_W  = clog2(CFG_W + 2);
    localparam int unsigned N_SRC  = N_IN + N_LUT;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_W + 1);

    logic [CFG_W-1:0]  r_cfg;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;
    logic              r_pen_q;

    logic [N_LUT-1:0]  w_c;
    logic [N_LUT-1:0]  w_q;
    logic [N_LUT-1:0]  w_mode;
    logic [N_SRC-1:0]  w_src;
    logic              w_run;
    logic [OSEL_W-1:0] w_osel;

    // LUT inputs only ever see registered values, so no comb loops exist.
    assign w_src = {w_q, fabric_in};
    assign w_run = r_valid & ~prog_en;

    for (genvar j = 0; j < int'(N_LUT); j++) begin : g_cell
        lut_cell #(
            .K     (K),
            .N_SRC (N_SRC),
            .SEL_W (SEL_W)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .i_src  (w_src),
            .i_cfg  (r_cfg[truth_off(j, CW) +: CW]),
            .i_en   (w_run),
            .o_c    (w_c[j]),
            .o_q    (w_q[j]),
            .o_mode (w_mode[j])
        );
    end

    always_comb begin
        fabric_out = '0;
        w_osel     = '0;
        for (int o = 0; o < int'(N_OUT); o++) begin
            w_osel = r_cfg[osel_off(o, N_LUT, CW, OSEL_W) +: OSEL_W];
            if (w_run && (32'(w_osel) < N_LUT)) begin
                fabric_out[o] = w_mode[w_osel] ? w_q[w_osel] : w_c[w_osel];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_pen_q <= 1'b0;
        end else begin
            r_pen_q <= prog_en;
            if (prog_en) begin
                r_cfg <= {prog_data, r_cfg[CFG_W-1:1]};
                if (!r_pen_q) begin
                    r_cnt   <= CNT_W'(1);
                    r_valid <= 1'b0;
                end else if (r_cnt != CNT_SAT) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (r_pen_q) begin
                r_valid <= (r_cnt == CNT_FULL);
            end
        end
    end

    assign prog_out  = r_cfg[0];
    assign cfg_valid = r_valid;

endmodule

// File: tb/tb_lut_fabric.sv
// Randomized self-checking bench for lut_fabric against a behavioural model
// that tracks session lengths and evaluates LUTs from the decoded bitstream.
module tb_lut_fabric;
    import lut_fabric_pkg::*;

    localparam int unsigned N_IN   = 5;
    localparam int unsigned N_OUT  = 5;
    localparam int unsigned N_LUT  = 8;
    localparam int unsigned K      = 3;
    localparam int unsigned SEL_W  = calc_sel_w(N_IN, N_LUT);
    localparam int unsigned OSEL_W = calc_osel_w(N_LUT);
    localparam int unsigned CW     = calc_cw(K, SEL_W);
    localparam int unsigned CFG_W  = calc_cfg_w(N_LUT, N_OUT, CW, OSEL_W);
    localparam int unsigned TT_W   = 32'd1 << K;

    logic             clk;
    logic             rst;
    logic             prog_en;
    logic             prog_data;
    logic             prog_out;
    logic [N_IN-1:0]  fabric_in;
    logic [N_OUT-1:0] fabric_out;
    logic             cfg_valid;

    int n_tests;
    int n_fail;

    // Behavioural model state.
    logic [CFG_W-1:0] m_cfg;
    logic [N_LUT-1:0] m_q;
    bit               m_valid;
    bit               m_in_session;
    int               m_len;

    logic [CFG_W-1:0] cfg_img;

    lut_fabric #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .N_LUT (N_LUT),
        .K     (K)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_en    (prog_en),
        .prog_data  (prog_data),
        .prog_out   (prog_out),
        .fabric_in  (fabric_in),
        .fabric_out (fabric_out),
        .cfg_valid  (cfg_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int field(input int unsigned off, input int unsigned w);
        int v;
        v = 0;
        for (int b = 0; b < int'(w); b++) begin
            v = v | (int'(m_cfg[off + b]) << b);
        end
        return v;
    endfunction

    function automatic bit m_comb(input int j, input logic [N_IN-1:0] fin);
        int addr;
        int s;
        bit x;
        addr = 0;
        for (int i = 0; i < int'(K); i++) begin
            s = field(sel_off(j, i, K, CW, SEL_W), SEL_W);
            if (s < int'(N_IN)) x = fin[s];
            else if (s < int'(N_IN + N_LUT)) x = m_q[s - int'(N_IN)];
            else x = 1'b0;
            addr = addr + (int'(x) << i);
        end
        return m_cfg[truth_off(j, CW) + addr];
    endfunction

    function automatic logic [N_OUT-1:0] m_out(input logic [N_IN-1:0] fin);
        logic [N_OUT-1:0] r;
        int s;
        r = '0;
        if (m_valid && !prog_en) begin
            for (int o = 0; o < int'(N_OUT); o++) begin
                s = field(osel_off(o, N_LUT, CW, OSEL_W), OSEL_W);
                if (s < int'(N_LUT)) begin
                    r[o] = m_cfg[mode_off(s, CW)] ? m_q[s] : m_comb(s, fin);
                end
            end
        end
        return r;
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_clock();
        logic [N_LUT-1:0] nq;
        if (rst) begin
            m_cfg = '0; m_q = '0; m_valid = 0; m_in_session = 0; m_len = 0;
        end else begin
            nq = '0;
            if (!prog_en && m_valid) begin
                for (int j = 0; j < int'(N_LUT); j++) nq[j] = m_comb(j, fabric_in);
            end
            if (prog_en) begin
                if (!m_in_session) begin
                    m_len   = 0;
                    m_valid = 0;
                end
                m_len++;
                m_cfg = {prog_data, m_cfg[CFG_W-1:1]};
            end else if (m_in_session) begin
                m_valid = (m_len == int'(CFG_W));
            end
            m_in_session = prog_en;
            m_q = nq;
        end
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [CFG_W-1:0] bits, input int len);
        prog_en = 1'b1;
        for (int n = 0; n < len; n++) begin
            prog_data = (n < int'(CFG_W)) ? bits[n] : 1'($urandom);
            step();
        end
        prog_en   = 1'b0;
        prog_data = 1'b0;
        step();
    endtask

    task automatic set_lut(input int j, input logic [TT_W-1:0] tt, input bit mode);
        cfg_img[truth_off(j, CW) +: TT_W] = tt;
        cfg_img[mode_off(j, CW)] = mode;
    endtask

    task automatic set_sel(input int j, input int i, input int s);
        cfg_img[sel_off(j, i, K, CW, SEL_W) +: SEL_W] = SEL_W'(s);
    endtask

    task automatic set_osel(input int o, input int s);
        cfg_img[osel_off(o, N_LUT, CW, OSEL_W) +: OSEL_W] = OSEL_W'(s);
    endtask

    task automatic random_img();
        for (int i = 0; i < int'(CFG_W); i++) cfg_img[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst = 1'b1; prog_en = 1'b1; prog_data = 1'b1; fabric_in = N_IN'($urandom);
        step();
        step();
        n_tests++;
        if (prog_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_prog_out got %b want 0", prog_out);
        end
        n_tests++;
        if (cfg_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_cfg_valid got %b want 0", cfg_valid);
        end
        n_tests++;
        if (fabric_out !== '0) begin
            n_fail++; $display("FAIL reset_fabric_out got %b want 0", fabric_out);
        end
        rst = 1'b0; prog_en = 1'b0; prog_data = 1'b0;
        step();
    endtask

    task automatic test_and_gate();
        logic [N_OUT-1:0] exp;
        cfg_img = '0;
        set_lut(0, 8'h08, 1'b0);
        set_sel(0, 0, 0); set_sel(0, 1, 1); set_sel(0, 2, 15);
        load(cfg_img, CFG_W);
        n_tests++;
        if (cfg_valid !== 1'b1) begin
            n_fail++; $display("FAIL and_cfg_valid got %b want 1", cfg_valid);
        end
        fabric_in = 5'b00011; #1;
        n_tests++;
        if (fabric_out[0] !== 1'b1) begin
            n_fail++; $display("FAIL and_11 got %b want 1", fabric_out[0]);
        end
        fabric_in = 5'b00001; #1;
        n_tests++;
        if (fabric_out[0] !== 1'b0) begin
            n_fail++; $display("FAIL and_01 got %b want 0", fabric_out[0]);
        end
        for (int t = 0; t < 8; t++) begin
            step();
            fabric_in = N_IN'($urandom); #1;
            exp = {N_OUT{fabric_in[0] & fabric_in[1]}};
            n_tests++;
            if (fabric_out !== exp || fabric_out !== m_out(fabric_in)) begin
                n_fail++;
                $display("FAIL and_rand in=%b got %b want %b", fabric_in, fabric_out, exp);
            end
        end
    endtask

    task automatic test_toggle();
        cfg_img = '0;
        set_lut(0, 8'h08, 1'b0);
        set_sel(0, 0, 0); set_sel(0, 1, 1); set_sel(0, 2, 15);
        set_lut(1, 8'h55, 1'b1);
        set_sel(1, 0, int'(N_IN) + 1);
        set_osel(1, 1);
        load(cfg_img, CFG_W);
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (fabric_out[1] !== 1'(k % 2) || fabric_out !== m_out(fabric_in)) begin
                n_fail++;
                $display("FAIL toggle k=%0d got %b want out1=%0d model %b",
                         k, fabric_out, k % 2, m_out(fabric_in));
            end
            fabric_in = N_IN'($urandom);
            step();
        end
        prog_en = 1'b1; prog_data = 1'($urandom); #1;
        n_tests++;
        if (fabric_out !== '0) begin
            n_fail++; $display("FAIL glitch_gate got %b want 0", fabric_out);
        end
        step();
        prog_en = 1'b0;
        step();
        n_tests++;
        if (cfg_valid !== 1'b0 || fabric_out !== '0) begin
            n_fail++;
            $display("FAIL glitch_after valid=%b out=%b want 0 0", cfg_valid, fabric_out);
        end
    endtask

    task automatic test_length();
        int lens [3];
        logic [N_OUT-1:0] exp;
        lens[0] = int'(CFG_W) - 1; lens[1] = int'(CFG_W) + 1; lens[2] = int'(CFG_W);
        foreach (lens[i]) begin
            random_img();
            load(cfg_img, lens[i]);
            n_tests++;
            if (cfg_valid !== 1'(lens[i] == int'(CFG_W))) begin
                n_fail++;
                $display("FAIL length_valid len=%0d got %b want %0d",
                         lens[i], cfg_valid, lens[i] == int'(CFG_W));
            end
            for (int t = 0; t < 6; t++) begin
                fabric_in = N_IN'($urandom); #1;
                exp = (lens[i] == int'(CFG_W)) ? m_out(fabric_in) : '0;
                n_tests++;
                if (fabric_out !== exp) begin
                    n_fail++;
                    $display("FAIL length_out len=%0d got %b want %b", lens[i], fabric_out, exp);
                end
                step();
            end
        end
    endtask

    task automatic test_readback();
        logic [CFG_W-1:0] p;
        for (int i = 0; i < int'(CFG_W); i++) p[i] = 1'($urandom_range(0, 1));
        prog_en = 1'b1;
        for (int n = 0; n < 2 * int'(CFG_W); n++) begin
            prog_data = (n < int'(CFG_W)) ? p[n] : 1'b0;
            step();
            if (n >= int'(CFG_W) - 1 && n <= 2 * int'(CFG_W) - 2) begin
                n_tests++;
                if (prog_out !== p[n + 1 - int'(CFG_W)]) begin
                    n_fail++;
                    $display("FAIL readback bit=%0d got %b want %b",
                             n + 1 - int'(CFG_W), prog_out, p[n + 1 - int'(CFG_W)]);
                end
            end
        end
        prog_en = 1'b0;
        step();
        n_tests++;
        if (cfg_valid !== 1'b0) begin
            n_fail++; $display("FAIL readback_valid got %b want 0", cfg_valid);
        end
    endtask

    task automatic test_reset_mid();
        prog_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            prog_data = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        n_tests++;
        if (prog_out !== 1'b0 || cfg_valid !== 1'b0 || fabric_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid prog_out=%b valid=%b out=%b want 0 0 0",
                     prog_out, cfg_valid, fabric_out);
        end
        rst = 1'b0; prog_en = 1'b0;
        step();
        random_img();
        load(cfg_img, CFG_W);
        n_tests++;
        if (cfg_valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_reload got %b want 1", cfg_valid);
        end
        for (int t = 0; t < 6; t++) begin
            fabric_in = N_IN'($urandom); #1;
            n_tests++;
            if (fabric_out !== m_out(fabric_in)) begin
                n_fail++;
                $display("FAIL reset_mid_out got %b want %b", fabric_out, m_out(fabric_in));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int len;
        for (int s = 0; s < 6; s++) begin
            random_img();
            case ($urandom_range(0, 3))
                0: len = 1;
                1: len = int'(CFG_W) - 1;
                default: len = int'(CFG_W);
            endcase
            load(cfg_img, len);
            for (int t = 0; t < 20; t++) begin
                fabric_in = N_IN'($urandom); #1;
                n_tests++;
                if (fabric_out !== m_out(fabric_in) || cfg_valid !== m_valid ||
                    prog_out !== m_cfg[0]) begin
                    n_fail++;
                    $display("FAIL b2b s=%0d t=%0d out=%b want %b valid=%b want %b", s, t,
                             fabric_out, m_out(fabric_in), cfg_valid, m_valid);
                end
                step();
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; prog_en = 1'b0; prog_data = 1'b0; fabric_in = '0;
        m_cfg = '0; m_q = '0; m_valid = 0; m_in_session = 0; m_len = 0;
        cfg_img = '0;
        test_reset();
        test_and_gate();
        test_toggle();
        test_length();
        test_readback();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
